wb_tracker: RTL and testbench
=============================

WB_TRACKER -- requirements
Module: wb_tracker

Interface
REQ-001 SHALL have port: cpu_clock_i  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL have port: cpu_reset_i  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have port: flush_i  in  1  pipeline flush; squashes all in-flight state.
REQ-004 SHALL have port: p0_we_dest  in  6  physical register written back.
REQ-005 SHALL have port: p0_wen  in  1  writeback valid; marks p0_we_dest ready.
REQ-006 SHALL have port: rob_id_i  in  5  ROB entry completing.
REQ-007 SHALL have port: rob_valid_i  in  1  completion valid; marks rob_id_i done.
REQ-008 SHALL have port: alloc_valid_i  in  1  rename allocates one ROB entry and one destination preg.
REQ-009 SHALL have port: alloc_preg_i  in  6  newly allocated destination preg; its ready bit is cleared.
REQ-010 SHALL have port: alloc_id_o  out  5  ROB id given to the allocation (tail pointer).
REQ-011 SHALL have port: full_o  out  1  32 entries in flight.
REQ-012 SHALL have port: rs_preg_a_i, rs_preg_b_i  in  6 each  operand readiness queries.
REQ-013 SHALL have port: rs_ready_a_o, rs_ready_b_o  out  1 each  query results.
REQ-014 SHALL have port: commit_valid_o  out  1  head entry in flight and done.
REQ-015 SHALL have port: commit_id_o  out  5  head ROB id.
REQ-016 SHALL have port: commit_ready_i  in  1  consumer accepts the head commit.

Function
REQ-017 SHALL hold ready[63:0], done[31:0], head[4:0], tail[4:0], count[5:0] (0..32).
REQ-018 SHALL set ready[p0_we_dest] at the edge when p0_wen=1 and flush_i=0.
REQ-019 SHALL clear ready[alloc_preg_i] on accepted allocation; same-cycle writeback to the same preg loses (ready ends 0).
REQ-020 SHALL treat preg 0 as permanently ready; writes and allocations to preg 0 are ignored.
REQ-021 SHALL compute rs_ready_x_o combinationally as ready[rs] OR (p0_wen AND p0_we_dest==rs AND rs!=0), bypassing same-cycle writeback.
REQ-022 SHALL accept allocation when alloc_valid_i=1, full_o=0 and flush_i=0: done[tail] cleared, tail+1 mod 32, count+1.
REQ-023 SHALL ignore allocation while full_o=1, even if a commit fires the same cycle.
REQ-024 SHALL set done[rob_id_i] when rob_valid_i=1 and flush_i=0; same-cycle allocation of that id wins (done ends 0).
REQ-025 SHALL drive commit_valid_o = (count!=0) AND done[head]; commit_id_o = head; full_o = (count==32).
REQ-026 SHALL retire when commit_valid_o AND commit_ready_i: head+1 mod 32, count-1; commit_valid_o SHALL not depend on commit_ready_i.
REQ-027 SHALL apply simultaneous accepted allocation and retirement as count unchanged, both pointers advancing.
REQ-028 SHALL give completion latency of one cycle: rob_valid_i at edge N makes commit_valid_o visible after edge N (if head).
REQ-029 SHALL, on flush_i=1, at the edge: head=tail=0, count=0, done all 0, ready all 1; all other same-cycle inputs ignored.
REQ-030 SHALL wrap head and tail from 31 to 0 without gaps.

Reset
REQ-031 SHALL, while cpu_reset_i=1, asynchronously force head=tail=0, count=0, done=0, ready=all ones; outputs: commit_valid_o=0, commit_id_o=0, alloc_id_o=0, full_o=0.
REQ-032 SHALL resume normal operation at the first edge after cpu_reset_i deasserts; reset mid-operation discards all entries.

Verification
REQ-033 SHALL verify: alloc preg 12 (id 0), query 12 -> 0; p0_wen dest 12 -> same-cycle query 1, next cycle ready[12]=1.
REQ-034 SHALL verify: alloc ids 0,1; rob_valid id 1 then id 0 -> commit_valid_o only after id 0 done; commits 0 then 1 in order.
REQ-035 SHALL verify: 32 allocs -> full_o=1; 33rd alloc with simultaneous commit -> ignored, count stays 31 after commit, alloc_id_o=0.
REQ-036 SHALL verify: alloc preg 7 and p0_wen dest 7 same cycle -> ready[7]=0; rob_valid id 3 with alloc of id 3 -> done[3]=0.
REQ-037 SHALL verify: 5 in flight, 3 done, flush_i=1 -> count=0, commit_valid_o=0, all queries 1, next alloc_id_o=0.
REQ-038 SHALL verify: 40 alloc/complete/commit cycles -> head and tail wrap 31->0, commit_id_o sequence continuous.

Source files
------------

// File: rtl/wb_tracker_if.sv
// Bundle of rename/writeback/completion/commit signals for the tracker.
// Latency: none (wires only).
// Backpressure: commit side uses valid/ready; allocation is gated by full_o.
interface wb_tracker_if;
    // writeback
    logic       p0_wen;
    logic [5:0] p0_we_dest;
    // completion
    logic       rob_valid_i;
    logic [4:0] rob_id_i;
    // allocation
    logic       alloc_valid_i;
    logic [5:0] alloc_preg_i;
    logic [4:0] alloc_id_o;
    logic       full_o;
    // operand readiness queries
    logic [5:0] rs_preg_a_i;
    logic [5:0] rs_preg_b_i;
    logic       rs_ready_a_o;
    logic       rs_ready_b_o;
    // commit
    logic       commit_valid_o;
    logic [4:0] commit_id_o;
    logic       commit_ready_i;
    // flush
    logic       flush_i;

    // driver side (rename / execute / retire logic)
    modport master (
        output p0_wen, p0_we_dest, rob_valid_i, rob_id_i,
               alloc_valid_i, alloc_preg_i, rs_preg_a_i, rs_preg_b_i,
               commit_ready_i, flush_i,
        input  alloc_id_o, full_o, rs_ready_a_o, rs_ready_b_o,
               commit_valid_o, commit_id_o
    );

    // tracker side
    modport slave (
        input  p0_wen, p0_we_dest, rob_valid_i, rob_id_i,
               alloc_valid_i, alloc_preg_i, rs_preg_a_i, rs_preg_b_i,
               commit_ready_i, flush_i,
        output alloc_id_o, full_o, rs_ready_a_o, rs_ready_b_o,
               commit_valid_o, commit_id_o
    );
endinterface

// File: rtl/wb_tracker.sv
// Physical-register scoreboard plus 32-entry in-order ROB completion tracker.
// Latency: queries combinational with writeback bypass; completion visible one edge later.
// Backpressure: allocation refused while full; head commit held until commit_ready_i.
module wb_tracker (
    input  logic         cpu_clock_i,
    input  logic         cpu_reset_i,
    wb_tracker_if.slave  bus
);

    logic [63:0] ready;
    logic [63:0] ready_nxt;
    logic [31:0] done;
    logic [31:0] done_nxt;
    logic [4:0]  head;
    logic [4:0]  head_nxt;
    logic [4:0]  tail;
    logic [4:0]  tail_nxt;
    logic [5:0]  count;
    logic [5:0]  count_nxt;

    logic        full;
    logic        commit_valid;
    logic        alloc_accept;
    logic        retire;
    logic        wb_live;

    // Occupancy and handshake qualifiers; a flush cancels every update.
    always_comb begin
        full         = (count == 6'd32);
        commit_valid = (count != 6'd0) && done[head];
        alloc_accept = bus.alloc_valid_i && !full && !bus.flush_i;
        retire       = commit_valid && bus.commit_ready_i && !bus.flush_i;
        wb_live      = bus.p0_wen && (bus.p0_we_dest != 6'd0);
    end

    // Output drive: commit_valid_o deliberately ignores commit_ready_i.
    always_comb begin
        bus.full_o         = full;
        bus.commit_valid_o = commit_valid;
        bus.commit_id_o    = head;
        bus.alloc_id_o     = tail;
        bus.rs_ready_a_o   = ready[bus.rs_preg_a_i] |
                             (wb_live && (bus.p0_we_dest == bus.rs_preg_a_i));
        bus.rs_ready_b_o   = ready[bus.rs_preg_b_i] |
                             (wb_live && (bus.p0_we_dest == bus.rs_preg_b_i));
    end

    // Next-state for the register scoreboard: allocation clear beats writeback set.
    always_comb begin
        ready_nxt = ready;
        if (wb_live && !bus.flush_i) begin
            ready_nxt[bus.p0_we_dest] = 1'b1;
        end
        if (alloc_accept && (bus.alloc_preg_i != 6'd0)) begin
            ready_nxt[bus.alloc_preg_i] = 1'b0;
        end
        if (bus.flush_i) begin
            ready_nxt = '1;
        end
        ready_nxt[0] = 1'b1;
    end

    // Next-state for ROB done bits: clearing the freshly allocated entry beats completion.
    always_comb begin
        done_nxt = done;
        if (bus.rob_valid_i && !bus.flush_i) begin
            done_nxt[bus.rob_id_i] = 1'b1;
        end
        if (alloc_accept) begin
            done_nxt[tail] = 1'b0;
        end
        if (bus.flush_i) begin
            done_nxt = '0;
        end
    end

    // Next-state for pointers and occupancy; 5-bit pointers wrap 31 -> 0 naturally.
    always_comb begin
        head_nxt  = head;
        tail_nxt  = tail;
        count_nxt = count;
        if (alloc_accept) begin
            tail_nxt = tail + 5'd1;
        end
        if (retire) begin
            head_nxt = head + 5'd1;
        end
        case ({alloc_accept, retire})
            2'b10:   count_nxt = count + 6'd1;
            2'b01:   count_nxt = count - 6'd1;
            default: count_nxt = count;
        endcase
        if (bus.flush_i) begin
            head_nxt  = 5'd0;
            tail_nxt  = 5'd0;
            count_nxt = 6'd0;
        end
    end

    // State registers; reset empties the ROB and marks every register ready.
    always_ff @(posedge cpu_clock_i or posedge cpu_reset_i) begin
        if (cpu_reset_i) begin
            ready <= '1;
            done  <= '0;
            head  <= 5'd0;
            tail  <= 5'd0;
            count <= 6'd0;
        end else begin
            ready <= ready_nxt;
            done  <= done_nxt;
            head  <= head_nxt;
            tail  <= tail_nxt;
            count <= count_nxt;
        end
    end

endmodule

// File: tb/tb_wb_tracker.sv
// Directed bench for wb_tracker: scoreboard bypass, ordered commit, full/flush/wrap.
// Latency: checks sampled 1-2 time units after the rising edge.
// Backpressure: commit_ready_i driven explicitly per step.
module tb_wb_tracker;

    logic clk;
    logic rst;
    int   n_assert;
    int   n_fail;
    int   exp_head;
    int   n_commit;

    wb_tracker_if bus ();

    wb_tracker dut (
        .cpu_clock_i (clk),
        .cpu_reset_i (rst),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.p0_wen         = 1'b0;
        bus.p0_we_dest     = 6'd0;
        bus.rob_valid_i    = 1'b0;
        bus.rob_id_i       = 5'd0;
        bus.alloc_valid_i  = 1'b0;
        bus.alloc_preg_i   = 6'd0;
        bus.rs_preg_a_i    = 6'd0;
        bus.rs_preg_b_i    = 6'd0;
        bus.commit_ready_i = 1'b0;
        bus.flush_i        = 1'b0;
    endtask

    // advance one edge and settle
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_flush();
        idle();
        bus.flush_i = 1'b1;
        tick();
        idle();
    endtask

    task automatic alloc(input logic [5:0] preg);
        idle();
        bus.alloc_valid_i = 1'b1;
        bus.alloc_preg_i  = preg;
        tick();
        idle();
    endtask

    task automatic complete(input logic [4:0] id);
        idle();
        bus.rob_valid_i = 1'b1;
        bus.rob_id_i    = id;
        tick();
        idle();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        idle();

        // ---- reset state (checked asynchronously, before any edge)
        rst = 1'b1;
        #2;
        bus.rs_preg_a_i = 6'd12;
        bus.rs_preg_b_i = 6'd63;
        #1;
        chk("rst_commit_valid", bus.commit_valid_o, 0);
        chk("rst_commit_id",    bus.commit_id_o,    0);
        chk("rst_alloc_id",     bus.alloc_id_o,     0);
        chk("rst_full",         bus.full_o,         0);
        chk("rst_ready_a",      bus.rs_ready_a_o,   1);
        chk("rst_ready_b",      bus.rs_ready_b_o,   1);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        idle();
        tick();

        // ---- allocation clears ready; writeback bypass then registered
        bus.alloc_valid_i = 1'b1;
        bus.alloc_preg_i  = 6'd12;
        #1;
        chk("alloc12_id", bus.alloc_id_o, 0);
        tick();
        idle();
        bus.rs_preg_a_i = 6'd12;
        #1;
        chk("q12_after_alloc", bus.rs_ready_a_o, 0);
        bus.p0_wen     = 1'b1;
        bus.p0_we_dest = 6'd12;
        #1;
        chk("q12_bypass", bus.rs_ready_a_o, 1);
        tick();
        idle();
        bus.rs_preg_a_i = 6'd12;
        #1;
        chk("q12_registered", bus.rs_ready_a_o, 1);

        // ---- out-of-order completion, in-order commit
        do_flush();
        chk("ooo_alloc0_id", bus.alloc_id_o, 0);
        alloc(6'd1);
        chk("ooo_alloc1_id", bus.alloc_id_o, 1);
        alloc(6'd2);
        complete(5'd1);
        chk("ooo_valid_after_id1", bus.commit_valid_o, 0);
        complete(5'd0);
        chk("ooo_valid_after_id0", bus.commit_valid_o, 1);
        chk("ooo_commit_id0",      bus.commit_id_o,    0);
        bus.commit_ready_i = 1'b1;
        tick();
        chk("ooo_valid_second", bus.commit_valid_o, 1);
        chk("ooo_commit_id1",   bus.commit_id_o,    1);
        tick();
        chk("ooo_valid_drained", bus.commit_valid_o, 0);
        chk("ooo_head_after",    bus.commit_id_o,    2);
        idle();

        // ---- full: 33rd allocation ignored even with simultaneous commit
        do_flush();
        bus.alloc_valid_i = 1'b1;
        bus.alloc_preg_i  = 6'd5;
        for (int i = 0; i < 32; i++) tick();
        idle();
        chk("full_after_32", bus.full_o,     1);
        chk("full_alloc_id", bus.alloc_id_o, 0);
        complete(5'd0);
        bus.alloc_valid_i  = 1'b1;
        bus.alloc_preg_i   = 6'd6;
        bus.commit_ready_i = 1'b1;
        #1;
        chk("full_commit_valid", bus.commit_valid_o, 1);
        tick();
        idle();
        chk("full_after_commit", bus.full_o,      0);
        chk("full_tail_held",    bus.alloc_id_o,  0);
        chk("full_head_moved",   bus.commit_id_o, 1);
        alloc(6'd6);
        chk("full_count31_plus1", bus.full_o,     1);
        chk("full_tail_wrapped",  bus.alloc_id_o, 1);

        // ---- same-cycle conflicts: allocation wins over writeback and completion
        do_flush();
        bus.alloc_valid_i = 1'b1;
        bus.alloc_preg_i  = 6'd7;
        bus.p0_wen        = 1'b1;
        bus.p0_we_dest    = 6'd7;
        tick();
        alloc(6'd0);
        alloc(6'd0);
        bus.rs_preg_a_i = 6'd7;
        bus.rs_preg_b_i = 6'd0;
        #1;
        chk("conf_ready7", bus.rs_ready_a_o, 0);
        chk("conf_preg0",  bus.rs_ready_b_o, 1);
        idle();
        bus.alloc_valid_i = 1'b1;
        bus.alloc_preg_i  = 6'd0;
        bus.rob_valid_i   = 1'b1;
        bus.rob_id_i      = 5'd3;
        #1;
        chk("conf_alloc_id3", bus.alloc_id_o, 3);
        tick();
        complete(5'd0);
        complete(5'd1);
        complete(5'd2);
        bus.commit_ready_i = 1'b1;
        tick();
        tick();
        tick();
        chk("conf_done3_clear", bus.commit_valid_o, 0);
        chk("conf_head3",       bus.commit_id_o,    3);
        complete(5'd3);
        chk("lat_done3_next_edge", bus.commit_valid_o, 1);
        bus.commit_ready_i = 1'b1;
        #1;
        chk("valid_indep_ready", bus.commit_valid_o, 1);
        bus.commit_ready_i = 1'b0;
        #1;

        // ---- flush with 5 in flight, 3 done, and noisy inputs
        do_flush();
        for (int i = 0; i < 5; i++) alloc(6'(10 + i));
        complete(5'd0);
        complete(5'd1);
        complete(5'd2);
        chk("fl_pre_valid", bus.commit_valid_o, 1);
        bus.flush_i        = 1'b1;
        bus.alloc_valid_i  = 1'b1;
        bus.alloc_preg_i   = 6'd20;
        bus.rob_valid_i    = 1'b1;
        bus.rob_id_i       = 5'd4;
        bus.commit_ready_i = 1'b1;
        tick();
        idle();
        bus.rs_preg_a_i = 6'd10;
        bus.rs_preg_b_i = 6'd20;
        #1;
        chk("fl_commit_valid", bus.commit_valid_o, 0);
        chk("fl_full",         bus.full_o,         0);
        chk("fl_alloc_id",     bus.alloc_id_o,     0);
        chk("fl_commit_id",    bus.commit_id_o,    0);
        chk("fl_q10",          bus.rs_ready_a_o,   1);
        chk("fl_q20",          bus.rs_ready_b_o,   1);

        // ---- 40-cycle streaming: pointers wrap, commit ids continuous
        exp_head = 0;
        n_commit = 0;
        for (int i = 0; i < 40; i++) begin
            idle();
            bus.alloc_valid_i  = 1'b1;
            bus.alloc_preg_i   = 6'd20;
            bus.commit_ready_i = 1'b1;
            if (i >= 1) begin
                bus.rob_valid_i = 1'b1;
                bus.rob_id_i    = 5'((i - 1) % 32);
            end
            #1;
            chk("wrap_alloc_id",     bus.alloc_id_o,     32'(i % 32));
            chk("wrap_commit_valid", bus.commit_valid_o, (i >= 2) ? 32'd1 : 32'd0);
            if (bus.commit_valid_o === 1'b1) begin
                chk("wrap_commit_id", bus.commit_id_o, 32'(exp_head));
                exp_head = (exp_head + 1) % 32;
                n_commit++;
            end
            tick();
        end
        idle();
        chk("wrap_commits", 32'(n_commit), 38);
        chk("wrap_head_end", bus.commit_id_o, 38 % 32);

        // ---- reset mid-operation discards entries
        alloc(6'd9);
        complete(5'd8);
        #2;
        rst = 1'b1;
        bus.rs_preg_a_i = 6'd9;
        #1;
        chk("mid_rst_alloc_id", bus.alloc_id_o,     0);
        chk("mid_rst_valid",    bus.commit_valid_o, 0);
        chk("mid_rst_q9",       bus.rs_ready_a_o,   1);
        @(negedge clk);
        rst = 1'b0;
        idle();
        alloc(6'd9);
        chk("post_rst_alloc_id", bus.alloc_id_o, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    // global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
